// File: rtl/bus_datapath_p.sv
// bus_datapath_p
//   Single-bus processor datapath: NREG general registers plus HI, LO, Y,
//   ZHI/ZLO and MDR, all exchanging data over one combinational bus that is
//   selected from one-hot source enables. An ALU takes A from Y and B from
//   the bus. Logic and arithmetic ops finish in one cycle. Signed MUL/DIV
//   are iterative and take WIDTH cycles behind a start/busy/done handshake.
//
//   Optional feature macro: R0_ZERO_EN
//     When it is defined, R0 always reads 0 and ignores reg_in[0]. reg_out[0]
//     still counts as a bus driver for priority and for bus_err.
//
// Ports
//   clk, clr            rising-edge clock, async active-high reset
//   reg_in/reg_out      per-register load / drive enables
//   hi_*/lo_*/y_in      HI, LO, Y load and drive enables
//   zhi_out/zlo_out     ALU result registers drive bus
//   mdr_in/mdr_read     load MDR; source 1=mdata_in, 0=bus
//   mdr_out, c_out      MDR / c_val drive bus
//   op, start           ALU opcode and start strobe
//   busy, done          iterative op running / one-cycle result pulse
//   bus, bus_err        bus value / two or more drivers active
//   mdr_q               MDR contents to memory
//
// ALU state machine
//   state   | meaning
//   ST_IDLE | accepts start; single-cycle ops complete here
//   ST_MUL  | shift-add multiply on operand magnitudes
//   ST_DIV  | restoring divide on operand magnitudes
module bus_datapath_p #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREG-1:0]  reg_in,
  input  logic [NREG-1:0]  reg_out,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             y_in,
  input  logic             mdr_in,
  input  logic             mdr_read,
  input  logic             mdr_out,
  input  logic [WIDTH-1:0] mdata_in,
  input  logic             c_out,
  input  logic [WIDTH-1:0] c_val,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] bus,
  output logic             bus_err,
  output logic [WIDTH-1:0] mdr_q
);

  localparam int SW   = $clog2(WIDTH);
  localparam int NSRC = NREG + 6;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] hi_q, lo_q, y_q, mdr_val_q, zhi_q, zlo_q;

  // ---------------- bus ----------------
  logic [NSRC-1:0] src_en;
  assign src_en  = {c_out, mdr_out, zlo_out, zhi_out, lo_out, hi_out, reg_out};
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign bus_err = |(src_en & (src_en - NSRC'(1)));

  // Lowest-priority source is assigned first so higher ones overwrite it.
  always_comb begin
    bus = '0;
    if (c_out)   bus = c_val;
    if (mdr_out) bus = mdr_val_q;
    if (zlo_out) bus = zlo_q;
    if (zhi_out) bus = zhi_q;
    if (lo_out)  bus = lo_q;
    if (hi_out)  bus = hi_q;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (reg_out[i]) bus = regs_q[i];
    end
  end

  // ---------------- register file and side registers ----------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      mdr_val_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_in[i]) regs_q[i] <= bus;
      end
`ifdef R0_ZERO_EN
      regs_q[0] <= '0;
`endif
      if (hi_in)  hi_q <= bus;
      if (lo_in)  lo_q <= bus;
      if (y_in)   y_q  <= bus;
      if (mdr_in) mdr_val_q <= mdr_read ? mdata_in : bus;
    end
  end

  assign mdr_q = mdr_val_q;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]   sum_d, diff_d;
  logic [SW-1:0]    amt;
  logic [SW:0]      inv_amt;
  logic [WIDTH-1:0] sc_hi_d, sc_lo_d;

  always_comb begin
    sum_d   = {1'b0, y_q} + {1'b0, bus};
    diff_d  = {1'b0, y_q} - {1'b0, bus};
    amt     = bus[SW-1:0];
    inv_amt = (SW+1)'(WIDTH) - {1'b0, amt};
    sc_hi_d = '0;
    sc_lo_d = '0;
    case (op)
      4'd0:  begin sc_lo_d = sum_d[WIDTH-1:0];  sc_hi_d = WIDTH'(sum_d[WIDTH]);  end
      4'd1:  begin sc_lo_d = diff_d[WIDTH-1:0]; sc_hi_d = WIDTH'(diff_d[WIDTH]); end
      4'd2:  sc_lo_d = y_q & bus;
      4'd3:  sc_lo_d = y_q | bus;
      4'd4:  sc_lo_d = y_q >> amt;
      4'd5:  sc_lo_d = y_q << amt;
      4'd6:  sc_lo_d = (y_q >> amt) | (y_q << inv_amt);
      4'd7:  sc_lo_d = (y_q << amt) | (y_q >> inv_amt);
      4'd10: sc_lo_d = -bus;
      4'd11: sc_lo_d = ~bus;
      default: ;
    endcase
  end

  // ---------------- iterative MUL/DIV ----------------
  state_t           state_q;
  logic             busy_q, done_q;
  logic [SW:0]      cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, a_q;
  logic             neg_q, neg_r_q, div0_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum, shifted, trial;
  logic [WIDTH-1:0]   mul_hi_d, mul_lo_d, div_hi_d, div_lo_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d, rem_d;

  always_comb begin
    mag_a    = y_q[WIDTH-1] ? -y_q : y_q;
    mag_b    = bus[WIDTH-1] ? -bus : bus;
    // MUL: acc_lo holds the multiplier, opnd the multiplicand.
    msum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_d = msum[WIDTH:1];
    mul_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
    // DIV: acc_lo holds the dividend shifting out / quotient shifting in.
    shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial    = shifted - {1'b0, opnd_q};
    div_hi_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    div_lo_d = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
    prod_d   = neg_q ? -{mul_hi_d, mul_lo_d} : {mul_hi_d, mul_lo_d};
    quo_d    = div0_q ? '1  : (neg_q   ? -div_lo_d : div_lo_d);
    rem_d    = div0_q ? a_q : (neg_r_q ? -div_hi_d : div_hi_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          if (op == 4'd8 || op == 4'd9) begin
            state_q  <= (op == 4'd8) ? ST_MUL : ST_DIV;
            busy_q   <= 1'b1;
            cnt_q    <= (SW+1)'(WIDTH - 1);
            acc_hi_q <= '0;
            acc_lo_q <= (op == 4'd8) ? mag_b : mag_a;
            opnd_q   <= (op == 4'd8) ? mag_a : mag_b;
            a_q      <= y_q;
            neg_q    <= y_q[WIDTH-1] ^ bus[WIDTH-1];
            neg_r_q  <= y_q[WIDTH-1];
            div0_q   <= (bus == '0);
          end else begin
            zhi_q  <= sc_hi_d;
            zlo_q  <= sc_lo_d;
            done_q <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_hi_q <= (state_q == ST_MUL) ? mul_hi_d : div_hi_d;
          acc_lo_q <= (state_q == ST_MUL) ? mul_lo_d : div_lo_d;
          if (cnt_q == '0) begin
            if (state_q == ST_MUL) begin
              zhi_q <= prod_d[2*WIDTH-1:WIDTH];
              zlo_q <= prod_d[WIDTH-1:0];
            end else begin
              zhi_q <= rem_d;
              zlo_q <= quo_d;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bus_datapath_p.sv
module tb_bus_datapath_p;
  localparam int W = 32;
  localparam int N = 16;
  localparam int NV = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic [N-1:0]  reg_in, reg_out;
  logic          hi_in, lo_in, hi_out, lo_out, zhi_out, zlo_out, y_in;
  logic          mdr_in, mdr_read, mdr_out, c_out, start;
  logic [W-1:0]  mdata_in, c_val;
  logic [3:0]    op;
  logic          busy, done, bus_err;
  logic [W-1:0]  bus, mdr_q;

  bus_datapath_p #(.WIDTH(W), .NREG(N)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .zhi_out(zhi_out), .zlo_out(zlo_out), .y_in(y_in),
    .mdr_in(mdr_in), .mdr_read(mdr_read), .mdr_out(mdr_out),
    .mdata_in(mdata_in), .c_out(c_out), .c_val(c_val), .op(op),
    .start(start), .busy(busy), .done(done), .bus(bus),
    .bus_err(bus_err), .mdr_q(mdr_q)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { logic [W-1:0] zhi; logic [W-1:0] zlo; int due; } exp_t;
  exp_t sbq[$];

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [3:0] op;
                   logic [W-1:0] zhi; logic [W-1:0] zlo; } vec_t;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_in = '0; reg_out = '0; hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0;
    zhi_out = 0; zlo_out = 0; y_in = 0; mdr_in = 0; mdr_out = 0; c_out = 0;
    start = 0;
  endtask

  task automatic load_reg(input int i, input logic [W-1:0] v);
    c_val = v; c_out = 1; reg_in = '0; reg_in[i] = 1'b1;
    tick();
    c_out = 0; reg_in = '0;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    c_val = v; c_out = 1; y_in = 1;
    tick();
    c_out = 0; y_in = 0;
  endtask

  // Drives B on the bus with start; expected result goes to the scoreboard.
  task automatic fire(input logic [W-1:0] b, input logic [3:0] o,
                      input logic [W-1:0] zhi, input logic [W-1:0] zlo);
    exp_t e;
    c_val = b; c_out = 1; op = o; start = 1;
    tick();
    start = 0; c_out = 0;
    e.zhi = zhi; e.zlo = zlo; e.due = cyc + ((o == 4'd8 || o == 4'd9) ? W : 0);
    sbq.push_back(e);
  endtask

  task automatic read_z(output logic [W-1:0] zhi, output logic [W-1:0] zlo);
    zlo_out = 1; #1; zlo = bus; zlo_out = 0;
    zhi_out = 1; #1; zhi = bus; zhi_out = 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    logic [W-1:0] zh, zl;
    if (sbq.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    if (e.due > cyc) chk({tag, "_busy_set"}, busy, 1);
    while (!done && cyc < e.due + 10) tick();
    chk({tag, "_done_cycle"}, cyc, e.due);
    chk({tag, "_busy_at_done"}, busy, 0);
    read_z(zh, zl);
    chk({tag, "_zlo"}, zl, e.zlo);
    chk({tag, "_zhi"}, zh, e.zhi);
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] o,
                                output logic [W-1:0] zhi, output logic [W-1:0] zlo);
    logic signed [2*W-1:0] ea, eb, p;
    logic signed [W-1:0] sa, sbv;
    sa = a; sbv = b; ea = sa; eb = sbv;
    if (o == 4'd8) begin
      p = ea * eb;
      zhi = p[2*W-1:W]; zlo = p[W-1:0];
    end else if (b == '0) begin
      zlo = '1; zhi = a;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      zlo = a; zhi = '0;
    end else begin
      zlo = sa / sbv; zhi = sa % sbv;
    end
  endfunction

  initial begin
    logic [W-1:0] zh, zl, ra, rb, r0_exp;
    logic [3:0] ro;
    int dn;

    vt[0]  = '{32'd5,         32'd7,         4'd0,  32'd0,         32'd12};
    vt[1]  = '{32'hFFFFFFFF,  32'd1,         4'd0,  32'd1,         32'd0};
    vt[2]  = '{32'd3,         32'd5,         4'd1,  32'd1,         32'hFFFFFFFE};
    vt[3]  = '{32'd5,         32'd3,         4'd1,  32'd0,         32'd2};
    vt[4]  = '{32'hF0F01234,  32'h0FF0FFFF,  4'd2,  32'd0,         32'h00F01234};
    vt[5]  = '{32'hF0000000,  32'h0000000F,  4'd3,  32'd0,         32'hF000000F};
    vt[6]  = '{32'h80000000,  32'd4,         4'd4,  32'd0,         32'h08000000};
    vt[7]  = '{32'h80000000,  32'd31,        4'd4,  32'd0,         32'd1};
    vt[8]  = '{32'd1,         32'h1F,        4'd5,  32'd0,         32'h80000000};
    vt[9]  = '{32'd1,         32'h21,        4'd5,  32'd0,         32'd2};
    vt[10] = '{32'd1,         32'd1,         4'd6,  32'd0,         32'h80000000};
    vt[11] = '{32'h12345678,  32'h20,        4'd6,  32'd0,         32'h12345678};
    vt[12] = '{32'h80000001,  32'd1,         4'd7,  32'd0,         32'd3};
    vt[13] = '{32'hFFFFFFFA,  32'd7,         4'd8,  32'hFFFFFFFF,  32'hFFFFFFD6};
    vt[14] = '{32'h00010000,  32'h00010000,  4'd8,  32'd1,         32'd0};
    vt[15] = '{32'h80000000,  32'h80000000,  4'd8,  32'h40000000,  32'd0};
    vt[16] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  4'd8,  32'd0,         32'd1};
    vt[17] = '{32'hFFFFFFF9,  32'd2,         4'd9,  32'hFFFFFFFF,  32'hFFFFFFFD};
    vt[18] = '{32'd9,         32'd0,         4'd9,  32'd9,         32'hFFFFFFFF};
    vt[19] = '{32'hFFFFFFF7,  32'd0,         4'd9,  32'hFFFFFFF7,  32'hFFFFFFFF};
    vt[20] = '{32'h80000000,  32'hFFFFFFFF,  4'd9,  32'd0,         32'h80000000};
    vt[21] = '{32'd7,         32'hFFFFFFFE,  4'd9,  32'd1,         32'hFFFFFFFD};
    vt[22] = '{32'd0,         32'd1,         4'd10, 32'd0,         32'hFFFFFFFF};
    vt[23] = '{32'd0,         32'h0F0F0F0F,  4'd11, 32'd0,         32'hF0F0F0F0};
    vt[24] = '{32'h1234,      32'h5678,      4'd12, 32'd0,         32'd0};
    vt[25] = '{32'hFFFF,      32'hFFFF,      4'd15, 32'd0,         32'd0};
    vt[26] = '{32'd100,       32'd7,         4'd9,  32'd2,         32'd14};

    idle();
    op = 0; c_val = 0; mdata_in = 0; mdr_read = 0;
    clr = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bus_idle", bus, 0);
    chk("reset_bus_err", bus_err, 0);
    chk("reset_mdr", mdr_q, 0);
    read_z(zh, zl);
    chk("reset_zlo", zl, 0);
    chk("reset_zhi", zh, 0);
    clr = 0;
    tick();

    // Directed ADD through the register file.
    load_reg(2, 32'd5);
    load_reg(4, 32'd7);
    reg_out[2] = 1; y_in = 1; tick(); idle();
    reg_out[4] = 1; op = 4'd0; start = 1;
    tick();
    idle();
    begin
      exp_t e;
      e.zhi = 0; e.zlo = 12; e.due = cyc;
      sbq.push_back(e);
    end
    wait_done("add_regs");
    tick();
    chk("done_one_cycle", done, 0);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      load_y(vt[i].a);
      fire(vt[i].b, vt[i].op, vt[i].zhi, vt[i].zlo);
      wait_done($sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d_done_low", i), done, 0);
    end

    // MUL with a start ignored mid-flight, then DIV issued on the done cycle.
    load_y(32'hFFFFFFFA);
    fire(32'd7, 4'd8, 32'hFFFFFFFF, 32'hFFFFFFD6);
    repeat (3) tick();
    c_val = 32'd1; c_out = 1; op = 4'd0; start = 1;
    tick();
    start = 0; c_out = 0;
    chk("ignored_start_busy", busy, 1);
    chk("ignored_start_no_done", done, 0);
    load_y(32'hFFFFFFF9);
    wait_done("b2b_mul");
    fire(32'd2, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done("b2b_div");
    tick();
    chk("b2b_done_low", done, 0);

    // Random MUL/DIV against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = (i == 3) ? 32'd0 : $urandom();
      if (i == 5) rb = {28'd0, rb[3:0]} | 32'd1;
      ro = 4'd8 + 4'($urandom_range(0, 1));
      model(ra, rb, ro, zh, zl);
      load_y(ra);
      fire(rb, ro, zh, zl);
      wait_done($sformatf("rnd%0d", i));
    end

    // Bus arbitration and MDR.
    load_reg(1, 32'h11111111);
    mdata_in = 32'hDEADBEEF; mdr_read = 1; mdr_in = 1; tick(); idle();
    chk("mdr_from_mem", mdr_q, 32'hDEADBEEF);
    mdr_out = 1; #1;
    chk("bus_mdr_alone", bus, 32'hDEADBEEF);
    chk("bus_err_single", bus_err, 0);
    reg_out[1] = 1; #1;
    chk("bus_r1_over_mdr", bus, 32'h11111111);
    chk("bus_err_two", bus_err, 1);
    idle(); #1;
    chk("bus_none", bus, 0);
    chk("bus_err_none", bus_err, 0);
    reg_out[1] = 1; mdr_read = 0; mdr_in = 1; tick(); idle();
    chk("mdr_from_bus", mdr_q, 32'h11111111);
    c_val = 32'hA5A5A5A5; c_out = 1; hi_in = 1; tick(); idle();
    c_val = 32'h5A5A5A5A; c_out = 1; lo_in = 1; tick(); idle();
    hi_out = 1; lo_out = 1; #1;
    chk("bus_hi_over_lo", bus, 32'hA5A5A5A5);
    chk("bus_err_hi_lo", bus_err, 1);
    idle(); lo_out = 1; c_out = 1; c_val = 32'h1; #1;
    chk("bus_lo_over_c", bus, 32'h5A5A5A5A);
    idle(); #1;

    // Reset during a MUL.
    load_y(32'hFFFFFFFA);
    c_val = 32'd7; c_out = 1; op = 4'd8; start = 1;
    tick();
    idle();
    repeat (9) tick();
    chk("mid_mul_busy", busy, 1);
    clr = 1; #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    #1 clr = 0;
    read_z(zh, zl);
    chk("clr_zlo", zl, 0);
    chk("clr_zhi", zh, 0);
    reg_out[2] = 1; #1;
    chk("clr_r2", bus, 0);
    idle();
    dn = 0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (done) dn++;
    end
    chk("no_done_after_clr", dn, 0);
    load_y(32'h80000001);
    fire(32'd1, 4'd7, 32'd0, 32'd3);
    wait_done("rol_after_clr");

    // R0 behaviour depends on the build option.
    load_reg(0, 32'hAA);
    reg_out[0] = 1; #1;
`ifdef R0_ZERO_EN
    r0_exp = 32'h0;
`else
    r0_exp = 32'hAA;
`endif
    chk("r0_read", bus, r0_exp);
    mdr_out = 1; #1;
    chk("r0_priority", bus, r0_exp);
    chk("r0_bus_err", bus_err, 1);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end
endmodule
